// File: rtl/cpu_step_ctrl_if.sv
// Bundle of the execution-controller signals between the board glue
// (switch/button/halt/clear sources, LED/HEX sinks) and cpu_step_ctrl.
interface cpu_step_ctrl_if #(
  parameter int CNT_W = 16
) ();
  logic             run_sw;
  logic             step_key_n;
  logic             halt;
  logic             clr_cnt;
  logic             cpu_en;
  logic [1:0]       mode;
  logic [CNT_W-1:0] step_cnt;
  logic             busy;

  modport master (
    output run_sw, step_key_n, halt, clr_cnt,
    input  cpu_en, mode, step_cnt, busy
  );

  modport slave (
    input  run_sw, step_key_n, halt, clr_cnt,
    output cpu_en, mode, step_cnt, busy
  );
endinterface

// File: rtl/cpu_step_ctrl.sv
// Execution controller for the teaching CPU: turns the step button and the
// run switch into a one-cycle clock-enable (cpu_en), detects halt, and keeps
// a saturating count of issued steps for the HEX/LEDR display.
module cpu_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RUN_DIV         = 8,
  parameter int CNT_W           = 16
) (
  input logic            clk,
  input logic            rst_n,
  cpu_step_ctrl_if.slave bus
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DIV_W = $clog2(RUN_DIV);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    STEP = 2'b01,
    RUN  = 2'b10,
    HALT = 2'b11
  } state_t;

  logic             key_meta_r, key_sync_r, key_db_r, key_db_s;
  logic [DB_W-1:0]  db_cnt_r, db_cnt_s;
  logic             press_r, press_s;
  logic             run_meta_r, run_sync_r;
  state_t           state_r, state_s;
  logic [DIV_W-1:0] div_r, div_s;
  logic             cpu_en_r, cpu_en_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             busy_r;

  // Debounce: the level only moves after DB_LAST+1 consecutive differing samples.
  always_comb begin
    key_db_s = key_db_r;
    db_cnt_s = DB_W'(0);
    press_s  = 1'b0;
    if (key_sync_r != key_db_r) begin
      if (db_cnt_r == DB_LAST) begin
        key_db_s = key_sync_r;
        db_cnt_s = DB_W'(0);
        press_s  = key_db_r;   // old level 1 -> new level 0 is a press
      end else begin
        db_cnt_s = db_cnt_r + DB_W'(1);
      end
    end else begin
      db_cnt_s = DB_W'(0);
    end
  end

  // Input synchronizers, debounced key level and registered press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta_r <= 1'b1;
      key_sync_r <= 1'b1;
      key_db_r   <= 1'b1;
      db_cnt_r   <= DB_W'(0);
      press_r    <= 1'b0;
      run_meta_r <= 1'b0;
      run_sync_r <= 1'b0;
    end else begin
      key_meta_r <= bus.step_key_n;
      key_sync_r <= key_meta_r;
      key_db_r   <= key_db_s;
      db_cnt_r   <= db_cnt_s;
      press_r    <= press_s;
      run_meta_r <= bus.run_sw;
      run_sync_r <= run_meta_r;
    end
  end

  // Next-state, run divider and cpu_en decode; halt overrides everything.
  always_comb begin
    state_s  = state_r;
    div_s    = DIV_W'(0);
    cpu_en_s = 1'b0;
    if (bus.halt) begin
      state_s = HALT;
    end else begin
      case (state_r)
        IDLE: begin
          if (run_sync_r) begin
            state_s = RUN;
          end else if (press_r && !cpu_en_r) begin
            // cpu_en_r is only high here as the trailing pulse of a RUN exit;
            // taking a press then would give back-to-back enables.
            state_s  = STEP;
            cpu_en_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end
        STEP: begin
          state_s = IDLE;
        end
        RUN: begin
          cpu_en_s = (div_r == DIV_LAST);
          if (run_sync_r) begin
            state_s = RUN;
            div_s   = (div_r == DIV_LAST) ? DIV_W'(0) : (div_r + DIV_W'(1));
          end else begin
            state_s = IDLE;
          end
        end
        HALT: begin
          if (press_r) begin
            state_s = IDLE;
          end else begin
            state_s = HALT;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // Saturating step counter; clear wins over a coincident increment.
  always_comb begin
    cnt_s = cnt_r;
    if (bus.clr_cnt) begin
      cnt_s = CNT_W'(0);
    end else if (cpu_en_s && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_s = cnt_r;
    end
  end

  // State, divider and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      div_r    <= DIV_W'(0);
      cpu_en_r <= 1'b0;
      cnt_r    <= CNT_W'(0);
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      div_r    <= div_s;
      cpu_en_r <= cpu_en_s;
      cnt_r    <= cnt_s;
      busy_r   <= (state_s == RUN);
    end
  end

  assign bus.cpu_en   = cpu_en_r;
  assign bus.mode     = state_r;
  assign bus.step_cnt = cnt_r;
  assign bus.busy     = busy_r;

endmodule

// File: doc/cpu_step_ctrl.md
Name: cpu_step_ctrl

Overview:
- Execution controller for the teaching computer's CPU.
- Turns the board step button and the run switch into a CPU clock-enable (cpu_en) that the CPU datapath gates every architectural update with.
- Supports single-step, free-run at a divided rate, and halt detection.
- Counts issued steps for display on HEX/LEDR.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable samples required before the debounced key level changes. Use 4 for simulation; the board build overrides it.
- RUN_DIV, 8: clocks between cpu_en pulses in RUN. Must be >= 2.
- CNT_W, 16: width of the step counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- run_sw  input  1  raw run switch (SW[8]); 1 = free-run.
- step_key_n  input  1  raw step push-button (KEY[3]); active-low.
- halt  input  1  CPU halt indication, synchronous to clk.
- clr_cnt  input  1  synchronous clear of step_cnt.
- cpu_en  output  1  one-cycle CPU advance enable.
- mode  output  2  current state encoding.
- step_cnt  output  CNT_W  saturating count of cpu_en pulses.
- busy  output  1  high while in RUN (LED).

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE, cpu_en=0, mode=2'b00, step_cnt=0, busy=0.
  - Key synchronizer and debounced level = 1; run synchronizer = 0.
  - Debounce and divider counters = 0.
  - Reset asserted mid-RUN or mid-STEP aborts immediately; no pulse is emitted after reset.
- Synchronizers: 2-FF chains on step_key_n and run_sw. halt is used directly.
- Debounce counter:
  - Increments each cycle the synchronized key differs from the debounced level.
  - Clears when they match.
  - When it would reach DEBOUNCE_CYCLES, the debounced level takes the new value and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never reach the debounced level.
- press: registered one-cycle pulse on a debounced 1->0 transition. Release generates nothing.
- States: IDLE=00, STEP=01, RUN=10, HALT=11.
- halt=1 has priority over every other transition from any state: next state HALT.
- IDLE:
  - run_s=1 -> RUN, divider cleared.
  - Otherwise press -> STEP.
  - run_s takes priority over a simultaneous press.
- STEP:
  - Lasts exactly one cycle.
  - cpu_en=1 in this cycle only.
  - Next state IDLE.
- RUN:
  - Divider counts 0..RUN_DIV-1 and wraps.
  - cpu_en=1 for the one cycle after the divider reaches RUN_DIV-1, so the first pulse follows RUN entry by RUN_DIV cycles, then one pulse every RUN_DIV cycles.
  - press is ignored.
  - run_s=0 -> IDLE and the divider clears; a pending pulse is still emitted if the divider was at RUN_DIV-1 that cycle.
- HALT:
  - cpu_en=0.
  - Exits to IDLE only on press with halt=0. A press while halt=1 is discarded, not queued.
- cpu_en is registered and is never high for two consecutive cycles in any mode.
- Step latency: cpu_en is high in the cycle following the (DEBOUNCE_CYCLES+2)-th rising edge after the edge that first samples step_key_n low. With the default, that is 6 edges. This holds with no debounce counter activity pending.
- step_cnt:
  - +1 on each cpu_en cycle.
  - Saturates at all-ones (no wrap).
  - clr_cnt=1 clears it to 0 and overrides a simultaneous increment.
- mode mirrors the state register. busy = (state==RUN).

Test Plan:
- Reset, then step_key_n low for 20 cycles then high, run_sw=0 -> exactly one cpu_en pulse, 6 edges after the first low sample; mode sequence 00->01->00; step_cnt=1.
- step_key_n low for 3 cycles only (glitch) -> no press, cpu_en stays 0, step_cnt=0.
- run_sw=1 held for 50 cycles after sync -> cpu_en pulses every 8 cycles, first 8 cycles after RUN entry; busy=1; step_cnt=6 after 48 cycles in RUN. Then run_sw=0 -> mode=00 and pulses stop.
- In RUN, assert halt=1 -> next state HALT, no further cpu_en. Press with halt=1 -> stays HALT. Drop halt, press -> IDLE.
- Preload step_cnt near saturation (CNT_W=4 override, 16 pulses) -> step_cnt holds 4'hF. clr_cnt together with a cpu_en pulse -> step_cnt=0.
- Assert rst_n low mid-RUN, between clock edges -> outputs clear immediately (cpu_en=0, mode=00, step_cnt=0). After release with run_sw=1, the first pulse arrives 8 cycles after RUN re-entry.
